// File: rtl/system_ecc_scrubber.sv
// Background SECDED scrubber: reads each word of a range, repairs single-bit errors by write-back,
// and counts correctable/uncorrectable words. States: IDLE, RD_REQ, RD_WAIT, CHECK, WB_REQ, NEXT, DONE.
module system_ecc_scrubber #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   num_words,
  input  logic                    clr_stats,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH+4:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH+4:0]   mem_rdata,
  output logic [CNT_WIDTH-1:0]    corr_count,
  output logic [CNT_WIDTH-1:0]    uncorr_count,
  output logic [ADDR_WIDTH-1:0]   last_err_addr,
  output logic                    err_pulse
);

  localparam int CW = DATA_WIDTH + 5;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, WB_REQ, NEXT, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remain_q;
  logic [CW-1:0]         rd_q;
  logic [CW-1:0]         wdata_q;
  logic [CNT_WIDTH-1:0]  corr_q;
  logic [CNT_WIDTH-1:0]  uncorr_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  err_q;

  logic [3:0]            syn;
  logic                  par;
  logic [11:0]           fixed;
  logic [DATA_WIDTH-1:0] data_fix;
  logic                  is_corr;
  logic                  is_uncorr;

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11];
    c[12] = ^c[11:0];
    return c;
  endfunction

  // Syndrome bit k covers every Hamming position with bit k set, parity bits included.
  always_comb begin
    syn[0] = rd_q[0] ^ rd_q[2] ^ rd_q[4] ^ rd_q[6] ^ rd_q[8] ^ rd_q[10];
    syn[1] = rd_q[1] ^ rd_q[2] ^ rd_q[5] ^ rd_q[6] ^ rd_q[9] ^ rd_q[10];
    syn[2] = rd_q[3] ^ rd_q[4] ^ rd_q[5] ^ rd_q[6] ^ rd_q[11];
    syn[3] = rd_q[7] ^ rd_q[8] ^ rd_q[9] ^ rd_q[10] ^ rd_q[11];
    par    = ^rd_q;
  end

  always_comb begin
    fixed = rd_q[11:0];
    if (par) begin
      for (int i = 0; i < 12; i++) begin
        if (syn == 4'(i + 1)) fixed[i] = ~rd_q[i];
      end
    end
  end

  assign data_fix  = {fixed[11], fixed[10], fixed[9], fixed[8],
                      fixed[6], fixed[5], fixed[4], fixed[2]};
  assign is_corr   = par && (syn <= 4'd12);
  assign is_uncorr = (!par && (syn != 4'd0)) || (par && (syn > 4'd12));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (num_words != '0) ? RD_REQ : DONE;
      end
      RD_REQ:  if (mem_gnt) state_nx = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_nx = CHECK;
      CHECK:   state_nx = is_corr ? WB_REQ : NEXT;
      WB_REQ:  if (mem_gnt) state_nx = NEXT;
      NEXT:    state_nx = (remain_q == ADDR_WIDTH'(1)) ? DONE : RD_REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == CHECK) && is_uncorr;
      if (state == IDLE && start && num_words != '0) begin
        addr_q   <= start_addr;
        remain_q <= num_words;
      end
      if (state == RD_WAIT && mem_rvalid) rd_q <= mem_rdata;
      if (state == CHECK && is_corr) wdata_q <= encode(data_fix);
      if (state == NEXT) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - ADDR_WIDTH'(1);
      end
    end
  end

  // A clear in the same cycle as a CHECK increment takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else if (clr_stats) begin
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else if (state == CHECK) begin
      if (is_corr) begin
        if (corr_q != '1) corr_q <= corr_q + CNT_WIDTH'(1);
        last_q <= addr_q;
      end else if (is_uncorr) begin
        if (uncorr_q != '1) uncorr_q <= uncorr_q + CNT_WIDTH'(1);
        last_q <= addr_q;
      end
    end
  end

  assign mem_req       = (state == RD_REQ) || (state == WB_REQ);
  assign mem_we        = (state == WB_REQ);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state == RD_REQ) || (state == RD_WAIT) || (state == CHECK) ||
                         (state == WB_REQ) || (state == NEXT);
  assign done          = (state == DONE);
  assign corr_count    = corr_q;
  assign uncorr_count  = uncorr_q;
  assign last_err_addr = last_q;
  assign err_pulse     = err_q;

endmodule
